// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, issues one imem request at a time and
// buffers responses, tagged with their PC, in a small FIFO feeding decode.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        misalign_err
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t        state_reg, state_next;
    logic [31:0]   pc_reg, pc_next;
    logic [31:0]   req_pc_reg, req_pc_next;
    logic          drop_reg, drop_next;
    logic          misalign_reg;
    logic [AW-1:0] rd_ptr_reg, wr_ptr_reg;
    logic [CW-1:0] count_reg, count_after;
    logic [31:0]   instr_mem [FIFO_DEPTH];
    logic [31:0]   pc_mem    [FIFO_DEPTH];

    logic accept, push, pop, credit, fifo_nonempty;

    assign fifo_nonempty = (count_reg != '0);
    assign accept        = (state_reg == REQ) && imem_req_ready;
    assign push          = (state_reg == WAIT) && imem_rsp_valid && !drop_reg && !redirect_valid;
    assign pop           = fifo_nonempty && instr_ready && !redirect_valid;
    // Occupancy after this cycle's push/pop; a same-cycle pop frees its slot.
    assign count_after   = count_reg + CW'(push) - CW'(pop);
    assign credit        = (count_after < CW'(FIFO_DEPTH));

    always_comb begin
        state_next  = state_reg;
        pc_next     = pc_reg;
        req_pc_next = req_pc_reg;
        drop_next   = drop_reg;
        case (state_reg)
            IDLE: if (credit) state_next = REQ;
            REQ: begin
                if (accept) begin
                    pc_next     = pc_reg + 32'd4;
                    req_pc_next = pc_reg;
                    state_next  = WAIT;
                end
            end
            WAIT: begin
                if (imem_rsp_valid) begin
                    drop_next  = 1'b0;
                    state_next = credit ? REQ : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        // A redirect overrides the sequential path; an in-flight request becomes stale.
        if (redirect_valid) begin
            pc_next = {redirect_pc[31:2], 2'b00};
            case (state_reg)
                REQ: begin
                    if (accept) begin
                        drop_next  = 1'b1;
                        state_next = WAIT;
                    end else begin
                        state_next = IDLE;
                    end
                end
                WAIT: begin
                    if (imem_rsp_valid) begin
                        drop_next  = 1'b0;
                        state_next = IDLE;
                    end else begin
                        drop_next  = 1'b1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            pc_reg       <= RESET_PC;
            req_pc_reg   <= '0;
            drop_reg     <= 1'b0;
            misalign_reg <= 1'b0;
            rd_ptr_reg   <= '0;
            wr_ptr_reg   <= '0;
            count_reg    <= '0;
        end else begin
            state_reg    <= state_next;
            pc_reg       <= pc_next;
            req_pc_reg   <= req_pc_next;
            drop_reg     <= drop_next;
            misalign_reg <= redirect_valid && (redirect_pc[1:0] != 2'b00);
            if (redirect_valid) begin
                rd_ptr_reg <= '0;
                wr_ptr_reg <= '0;
                count_reg  <= '0;
            end else begin
                if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
                if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
                count_reg <= count_after;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wr_ptr_reg] <= imem_rsp_data;
            pc_mem[wr_ptr_reg]    <= req_pc_reg;
        end
    end

    assign imem_req_valid = (state_reg == REQ);
    assign imem_addr      = pc_reg;
    assign instr_valid    = fifo_nonempty;
    assign instr          = fifo_nonempty ? instr_mem[rd_ptr_reg] : '0;
    assign instr_pc       = fifo_nonempty ? pc_mem[rd_ptr_reg] : '0;
    assign misalign_err   = misalign_reg;

    // imem must only respond while a request is outstanding.
    rsp_in_wait_only: assert property (@(posedge clk) disable iff (reset)
        !(imem_rsp_valid && (state_reg != WAIT)));
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: an imem model logs accepted addresses and
// a scoreboard queue of expected {data, pc} is checked by an independent monitor.
module tb_instr_fetch_unit;
    typedef struct packed {
        logic [31:0] data;
        logic [31:0] pc;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid, instr_ready;
    logic [31:0] instr, instr_pc;
    logic        misalign_err;

    logic        d2_req_valid, d2_req_ready, d2_rsp_valid;
    logic [31:0] d2_addr, d2_rsp_data, d2_redirect_pc, d2_instr, d2_instr_pc;
    logic        d2_redirect_valid, d2_instr_valid, d2_instr_ready, d2_misalign;

    int errors = 0;
    int checks = 0;

    exp_t        exp_q[$];
    logic [31:0] acc_q[$];
    logic [31:0] acc2_q[$];

    logic        ready_ctl, hold, pend, p2;
    int          rsp_lat, pend_wait;
    logic [31:0] pend_addr, p2_addr;

    instr_fetch_unit dut (
        .clk(clk), .reset(reset),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_addr(imem_addr), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
        .misalign_err(misalign_err)
    );

    instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .FIFO_DEPTH(2)) dut2 (
        .clk(clk), .reset(reset),
        .imem_req_valid(d2_req_valid), .imem_req_ready(d2_req_ready),
        .imem_addr(d2_addr), .imem_rsp_valid(d2_rsp_valid),
        .imem_rsp_data(d2_rsp_data), .redirect_valid(d2_redirect_valid),
        .redirect_pc(d2_redirect_pc), .instr_valid(d2_instr_valid),
        .instr_ready(d2_instr_ready), .instr(d2_instr), .instr_pc(d2_instr_pc),
        .misalign_err(d2_misalign)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] dfun(input logic [31:0] a);
        return a ^ 32'h5A5A_C3C3;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic fail_timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got timeout expected event", name);
    endtask

    function automatic logic [31:0] acc_at(input int i);
        if (i < acc_q.size()) return acc_q[i];
        return 32'hDEAD_BEEF;
    endfunction

    task automatic expect_instr(input logic [31:0] pc);
        exp_q.push_back('{data: dfun(pc), pc: pc});
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req_valid"}, {31'd0, imem_req_valid}, 32'd0);
        chk({tag, "_addr"}, imem_addr, 32'h0000_0000);
        chk({tag, "_instr_valid"}, {31'd0, instr_valid}, 32'd0);
        chk({tag, "_instr"}, instr, 32'd0);
        chk({tag, "_instr_pc"}, instr_pc, 32'd0);
        chk({tag, "_misalign"}, {31'd0, misalign_err}, 32'd0);
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        hold = 1'b0;
        redirect_valid = 1'b0;
        repeat (3) tick();
        check_reset_outputs(tag);
        chk({tag, "_d2_addr"}, d2_addr, 32'hFFFF_FFFC);
        chk({tag, "_d2_outs"}, {29'd0, d2_req_valid, d2_instr_valid, d2_misalign}, 32'd0);
        chk({tag, "_d2_head"}, d2_instr | d2_instr_pc, 32'd0);
        acc_q.delete();
        exp_q.delete();
        reset = 1'b0;
    endtask

    task automatic wait_acc(input int n, input string name);
        int k = 0;
        while (acc_q.size() < n && k < 100) begin
            tick();
            k++;
        end
        if (acc_q.size() < n) fail_timeout(name);
    endtask

    task automatic drain_wait(input string name);
        int k = 0;
        while (exp_q.size() != 0 && k < 200) begin
            tick();
            k++;
        end
        if (exp_q.size() != 0) fail_timeout(name);
        instr_ready = 1'b0;
    endtask

    // imem model for the main DUT: accepts when ready_ctl, answers rsp_lat cycles later.
    initial begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        imem_req_ready = 1'b0;
        pend = 1'b0;
        pend_wait = 0;
        pend_addr = '0;
        forever begin
            @(negedge clk);
            #1;
            imem_rsp_valid = 1'b0;
            if (pend && !hold) begin
                if (pend_wait == 0) begin
                    imem_rsp_valid = 1'b1;
                    imem_rsp_data  = dfun(pend_addr);
                    pend = 1'b0;
                end else begin
                    pend_wait--;
                end
            end
            imem_req_ready = ready_ctl;
            if (!reset && imem_req_valid === 1'b1 && ready_ctl) begin
                pend = 1'b1;
                pend_wait = rsp_lat - 1;
                pend_addr = imem_addr;
                acc_q.push_back(imem_addr);
                $display("imem accept addr=%h", imem_addr);
            end
        end
    end

    // imem model for the RESET_PC=0xFFFF_FFFC instance: always ready, 1-cycle response.
    initial begin
        d2_req_ready = 1'b1;
        d2_rsp_valid = 1'b0;
        d2_rsp_data  = '0;
        d2_redirect_valid = 1'b0;
        d2_redirect_pc = '0;
        d2_instr_ready = 1'b1;
        p2 = 1'b0;
        p2_addr = '0;
        forever begin
            @(negedge clk);
            #1;
            d2_rsp_valid = p2;
            d2_rsp_data  = dfun(p2_addr);
            p2 = 1'b0;
            if (!reset && d2_req_valid === 1'b1) begin
                p2 = 1'b1;
                p2_addr = d2_addr;
                acc2_q.push_back(d2_addr);
            end
        end
    end

    // Scoreboard monitor: every decode handshake pops one expected entry.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!reset && instr_valid === 1'b1 && instr_ready && !redirect_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_instr: got pc=%h data=%h expected none", instr_pc, instr);
                end else begin
                    e = exp_q.pop_front();
                    $display("decode pc=%h instr=%h (expect pc=%h instr=%h)", instr_pc, instr, e.pc, e.data);
                    chk("sb_pc", instr_pc, e.pc);
                    chk("sb_instr", instr, e.data);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        ready_ctl = 1'b1;
        instr_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        hold = 1'b0;
        rsp_lat = 1;

        // 1: streaming fetch with 1-cycle imem
        do_reset("t1_reset");
        expect_instr(32'h0); expect_instr(32'h4); expect_instr(32'h8);
        tick();
        chk("t1_first_req_valid", {31'd0, imem_req_valid}, 32'd1);
        chk("t1_first_req_addr", imem_addr, 32'h0);
        drain_wait("t1_drain");
        chk("t1_addr0", acc_at(0), 32'h0);
        chk("t1_addr1", acc_at(1), 32'h4);
        chk("t1_addr2", acc_at(2), 32'h8);
        chk("t5_wrap_addr0", acc2_q.size() > 0 ? acc2_q[0] : 32'hDEAD_BEEF, 32'hFFFF_FFFC);
        chk("t5_wrap_addr1", acc2_q.size() > 1 ? acc2_q[1] : 32'hDEAD_BEEF, 32'h0000_0000);

        // 2: decode stalled, buffer fills to depth and fetch stops
        instr_ready = 1'b0;
        do_reset("t2_reset");
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (i >= 6) chk("t2_req_idle", {31'd0, imem_req_valid}, 32'd0);
        end
        chk("t2_buffered", acc_q.size(), 32'd2);
        chk("t2_head_valid", {31'd0, instr_valid}, 32'd1);
        chk("t2_head_pc", instr_pc, 32'h0);
        chk("t2_head_instr", instr, dfun(32'h0));
        expect_instr(32'h0); expect_instr(32'h4); expect_instr(32'h8);
        instr_ready = 1'b1;
        drain_wait("t2_drain");
        chk("t2_resume_addr", acc_at(2), 32'h8);

        // 3: redirect while waiting on 0x8 (2-cycle imem) drops that response
        rsp_lat = 2;
        instr_ready = 1'b1;
        do_reset("t3_reset");
        expect_instr(32'h0); expect_instr(32'h4); expect_instr(32'h100);
        wait_acc(3, "t3_wait_req8");
        chk("t3_addr2", acc_at(2), 32'h8);
        chk("t3_fifo_empty", {31'd0, instr_valid}, 32'd0);
        redirect_valid = 1'b1;
        redirect_pc = 32'h100;
        tick();
        redirect_valid = 1'b0;
        drain_wait("t3_drain");
        chk("t3_redirect_addr", acc_at(3), 32'h100);
        rsp_lat = 1;

        // 4: misaligned redirect in REQ, then redirect on an accepted request
        ready_ctl = 1'b0;
        instr_ready = 1'b1;
        do_reset("t4_reset");
        tick();
        chk("t4_req_before", {31'd0, imem_req_valid}, 32'd1);
        redirect_valid = 1'b1;
        redirect_pc = 32'h203;
        tick();
        redirect_valid = 1'b0;
        chk("t4_misalign_pulse", {31'd0, misalign_err}, 32'd1);
        chk("t4_req_dropped", {31'd0, imem_req_valid}, 32'd0);
        tick();
        chk("t4_misalign_clear", {31'd0, misalign_err}, 32'd0);
        chk("t4_req_again", {31'd0, imem_req_valid}, 32'd1);
        chk("t4_aligned_addr", imem_addr, 32'h200);
        ready_ctl = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h300;
        expect_instr(32'h300);
        tick();
        redirect_valid = 1'b0;
        drain_wait("t4_drain");
        chk("t4_stale_addr", acc_at(0), 32'h200);
        chk("t4_new_addr", acc_at(1), 32'h300);

        // 6: request held while not ready, then reset mid-WAIT with a late response
        ready_ctl = 1'b0;
        instr_ready = 1'b1;
        do_reset("t6_reset");
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("t6_hold_valid", {31'd0, imem_req_valid}, 32'd1);
            chk("t6_hold_addr", imem_addr, 32'h0);
            tick();
        end
        ready_ctl = 1'b1;
        hold = 1'b1;
        tick();
        chk("t6_in_wait", {31'd0, imem_req_valid}, 32'd0);
        tick();
        reset = 1'b1;
        hold = 1'b0;
        tick();
        check_reset_outputs("t6_mid_wait_reset");
        reset = 1'b0;
        ready_ctl = 1'b0;
        tick();
        chk("t6_late_rsp_ignored", {31'd0, instr_valid}, 32'd0);
        tick();
        chk("t6_late_rsp_ignored2", {31'd0, instr_valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
